bw_seq_mult: RTL and testbench
==============================

Name: bw_seq_mult

Overview:
- Parametrised, iterative Baugh-Wooley multiplier. It is the sequential successor of the fixed 7x5 combinational array.
- Produces one partial-product row per clock and adds it into an accumulator. A start/done handshake wraps the computation.
- Supports a signed (two's complement, Baugh-Wooley) mode and an unsigned mode, selected per operation.
- Sits beside the lab datapath blocks as a shared multiply resource.

Parameters:
- AW, 7, multiplicand width in bits; must be >= 2.
- BW, 5, multiplier width in bits; must be >= 2. It also sets compute latency.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while in_ready=1.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- a  input  AW  multiplicand; captured with start.
- b  input  BW  multiplier; captured with start.
- in_ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when p is updated.
- p  output  AW+BW  product; holds last result until next done.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1, busy=0, done=0, p=0; internal a_r, b_r, acc, cnt cleared.
- States:
  - IDLE: in_ready=1. If start=1: capture a_r=a, b_r=b, mode_r=signed_mode; acc=K(mode); cnt=0; go to RUN.
  - RUN: busy=1. acc += row(cnt) << cnt; cnt++. When cnt==BW-1 (last row): p <= acc_next; go to DONE.
  - DONE: done=1 for exactly one cycle; then go to IDLE.
- Latency: start sampled at edge 0; done=1 and p valid in cycle BW+1; in_ready returns 1 the cycle after done.
- Throughput: one operation per BW+2 cycles.
- Row generation, unsigned mode: bit j of row i = a_r[j] & b_r[i]. K = 0.
- Row generation, signed mode:
  - Rows i < BW-1: bit AW-1 is inverted (~(a_r[AW-1]&b_r[i])); other bits are plain AND.
  - Row BW-1: bits 0..AW-2 are inverted; bit AW-1 is plain AND.
  - K = 2^(AW+BW-1) + 2^(AW-1) + 2^(BW-1), computed mod 2^(AW+BW).
- Arithmetic: acc is AW+BW bits wide; all additions are mod 2^(AW+BW); carries beyond the MSB are discarded.
- start while busy or in DONE: ignored, not queued. Operands and mode seen during RUN have no effect.
- start in the same cycle as a DONE->IDLE transition: not accepted, because in_ready=0 during DONE.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted with no done pulse, and all outputs take their reset values immediately.
- p is written only on the RUN->DONE transition and is stable otherwise.

Decomposition:
- Shared package bw_pkg:
  - State enum (IDLE, RUN, DONE).
  - Function bw_const(aw, bw, signed) returning K.
  - Counter-width helper clog2.
- One natural sub-module: bw_pp_row. It is combinational, takes (a_r, b_bit, last_row, signed_mode) and returns the AW-bit row with the Baugh-Wooley inversions applied.
- The accumulator adder is a plain `+`; no FA instances are required.

Test Plan:
- Signed a=-64 (0x40), b=-16 (0x10), AW=7, BW=5 -> done at cycle 6, p=0x400 (1024).
- Signed a=63, b=15 -> p=0x3B1 (945). Signed a=-64, b=15 -> p=0xC40 (-960). Signed a=-1, b=-1 -> p=0x001.
- Unsigned a=0x7F, b=0x1F -> p=0xF61 (3937). Same operands signed -> p=0x001.
- start pulsed every cycle with changing operands -> only the IDLE-sampled operands are used. Exactly one done per BW+2 cycles; in_ready=0 throughout RUN and DONE.
- rst_n low at cycle 3 of a RUN -> immediate p=0, busy=0, done=0, in_ready=1. No done follows; the next start computes correctly.
- Parameter sweeps AW=BW=4 and AW=8, BW=3: exhaustive over all operands in both modes against a reference model; also check p stability between done pulses.

Source files
------------

// File: rtl/bw_pkg.sv
// Shared definitions for the sequential Baugh-Wooley multiplier:
// controller states, the correction constant K and a width helper.
package bw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of bits needed to count 0..value-1. Never returns less than 1.
    function automatic int clog2(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Baugh-Wooley correction constant. It is zero for unsigned operands.
    // The caller keeps only the low aw+bw bits, which reduces the result mod 2^(aw+bw).
    function automatic logic [63:0] bw_const(input int aw, input int bw, input logic sgn);
        logic [63:0] k;
        k = 64'd0;
        if (sgn) begin
            k = (64'd1 << (aw + bw - 1)) + (64'd1 << (aw - 1)) + (64'd1 << (bw - 1));
        end
        return k;
    endfunction

endpackage

// File: rtl/bw_pp_row.sv
// One partial-product row. Each bit is a[j] & b_bit. In signed mode the
// Baugh-Wooley inversions are applied: the MSB is inverted on ordinary rows,
// and every bit except the MSB is inverted on the last row.
module bw_pp_row
    import bw_pkg::*;
#(
    parameter int AW = 7
) (
    input  logic [AW-1:0] a_r,
    input  logic          b_bit,
    input  logic          last_row,
    input  logic          signed_mode,
    output logic [AW-1:0] row
);

    genvar gi;
    generate
        for (gi = 0; gi < AW; gi = gi + 1) begin : g_bit
            logic flip;
            // The MSB is inverted on every row except the last one. The other
            // bits are inverted only on the last row.
            assign flip    = signed_mode & ((gi == AW - 1) ? ~last_row : last_row);
            assign row[gi] = (a_r[gi] & b_bit) ^ flip;
        end
    endgenerate

endmodule

// File: rtl/bw_seq_mult.sv
// Iterative Baugh-Wooley multiplier. The accumulator is seeded with K, one
// shifted partial-product row is added per clock, and done pulses once per
// operation. The product register p holds its value until the next done.
module bw_seq_mult
    import bw_pkg::*;
#(
    parameter int AW = 7,
    parameter int BW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [AW-1:0]    a,
    input  logic [BW-1:0]    b,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [AW+BW-1:0] p
);

    localparam int              PW       = AW + BW;
    localparam int              CW       = clog2(BW);
    localparam logic [63:0]     K_SIGNED = bw_const(AW, BW, 1'b1);
    localparam logic [CW-1:0]   LAST     = CW'(BW - 1);

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   a_r;
    logic [BW-1:0]   b_r;
    logic            mode_r;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_next;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   row;
    logic [PW-1:0]   row_ext;
    logic            last_row;

    assign last_row = (cnt == LAST);
    assign row_ext  = {{BW{1'b0}}, row};

    bw_pp_row #(.AW(AW)) u_row (
        .a_r         (a_r),
        .b_bit       (b_r[cnt]),
        .last_row    (last_row),
        .signed_mode (mode_r),
        .row         (row)
    );

    // Accumulator update. The carry out of the MSB is dropped.
    always_comb begin
        acc_next = acc + (row_ext << cnt);
    end

    // Next-state logic and status outputs, all decoded from the state.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_row) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Datapath: capture operands in IDLE, accumulate rows in RUN, publish p on the last row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            mode_r <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            p      <= '0;
        end else begin
            if (state == IDLE && start) begin
                a_r    <= a;
                b_r    <= b;
                mode_r <= signed_mode;
                acc    <= signed_mode ? K_SIGNED[PW-1:0] : '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
                if (last_row) p <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_bw_seq_mult.sv
// Self-checking bench for bw_seq_mult. It drives three instances, with
// (AW,BW) = (7,5), (4,4) and (8,3), and checks them against an
// integer-arithmetic product model.
module tb_bw_seq_mult;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int AWS [3] = '{7, 4, 8};
    int BWS [3] = '{5, 4, 3};

    // instance 0: AW=7 BW=5
    logic        start0 = 0, sm0 = 0, rdy0, busy0, done0;
    logic [6:0]  a0 = '0;
    logic [4:0]  b0 = '0;
    logic [11:0] p0;
    // instance 1: AW=4 BW=4
    logic        start1 = 0, sm1 = 0, rdy1, busy1, done1;
    logic [3:0]  a1 = '0;
    logic [3:0]  b1 = '0;
    logic [7:0]  p1;
    // instance 2: AW=8 BW=3
    logic        start2 = 0, sm2 = 0, rdy2, busy2, done2;
    logic [7:0]  a2 = '0;
    logic [2:0]  b2 = '0;
    logic [10:0] p2;

    bw_seq_mult #(.AW(7), .BW(5)) dut0 (.clk(clk), .rst_n(rst_n), .start(start0), .signed_mode(sm0),
        .a(a0), .b(b0), .in_ready(rdy0), .busy(busy0), .done(done0), .p(p0));
    bw_seq_mult #(.AW(4), .BW(4)) dut1 (.clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(sm1),
        .a(a1), .b(b1), .in_ready(rdy1), .busy(busy1), .done(done1), .p(p1));
    bw_seq_mult #(.AW(8), .BW(3)) dut2 (.clk(clk), .rst_n(rst_n), .start(start2), .signed_mode(sm2),
        .a(a2), .b(b2), .in_ready(rdy2), .busy(busy2), .done(done2), .p(p2));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: interpret the operands as integers (two's complement
    // when sgn=1), multiply them, and keep the low aw+bw bits.
    function automatic logic [31:0] ref_prod(input int aw, input int bw, input bit sgn,
                                             input logic [31:0] a, input logic [31:0] b);
        longint av, bv, prod, pmask;
        av = longint'(a) & ((64'sd1 <<< aw) - 1);
        bv = longint'(b) & ((64'sd1 <<< bw) - 1);
        if (sgn && av >= (64'sd1 <<< (aw - 1))) av = av - (64'sd1 <<< aw);
        if (sgn && bv >= (64'sd1 <<< (bw - 1))) bv = bv - (64'sd1 <<< bw);
        prod  = av * bv;
        pmask = (64'sd1 <<< (aw + bw)) - 1;
        return 32'(prod & pmask);
    endfunction

    task automatic drive(input int sel, input bit st, input bit sm, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            0: begin start0 = st; sm0 = sm; a0 = a[6:0]; b0 = b[4:0]; end
            1: begin start1 = st; sm1 = sm; a1 = a[3:0]; b1 = b[3:0]; end
            default: begin start2 = st; sm2 = sm; a2 = a[7:0]; b2 = b[2:0]; end
        endcase
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
    endfunction
    function automatic logic get_ready(input int sel);
        return (sel == 0) ? rdy0 : (sel == 1) ? rdy1 : rdy2;
    endfunction
    function automatic logic [31:0] get_p(input int sel);
        return (sel == 0) ? 32'(p0) : (sel == 1) ? 32'(p1) : 32'(p2);
    endfunction

    // One full operation. Operands are scrambled while the instance is
    // running, to show they are ignored. Latency, product and p-hold are checked.
    task automatic run_op(input int sel, input bit sm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int n;
        @(negedge clk);
        check_eq("ready_idle", 32'(get_ready(sel)), 32'd1);
        drive(sel, 1'b1, sm, a, b);
        @(negedge clk);
        n = 1;
        check_eq("busy_run", 32'({get_busy(sel), get_ready(sel)}), 32'd2);
        drive(sel, 1'b0, ~sm, ~a, ~b);
        while (!get_done(sel) && n < 40) begin
            @(negedge clk);
            n++;
            drive(sel, 1'b0, 1'($urandom), $urandom, $urandom);
        end
        check_eq("latency", 32'(n), 32'(BWS[sel] + 1));
        check_eq("product", get_p(sel), exp);
        $display("op sel=%0d mode=%0d a=0x%0h b=0x%0h p=0x%0h exp=0x%0h lat=%0d",
                 sel, sm, a, b, get_p(sel), exp, n);
        @(negedge clk);
        check_eq("post_done", 32'({get_done(sel), get_ready(sel)}), 32'd1);
        check_eq("p_hold", get_p(sel), exp);
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          rs;
        logic [31:0] exp_q[$];
        logic [31:0] e;
        int          last_done;
        int          seen_done;

        // Reset state on every instance.
        #1;
        for (int s = 0; s < 3; s++) begin
            check_eq("rst_ready", 32'(get_ready(s)), 32'd1);
            check_eq("rst_busy", 32'(get_busy(s)), 32'd0);
            check_eq("rst_done", 32'(get_done(s)), 32'd0);
            check_eq("rst_p", get_p(s), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases on the 7x5 instance, with expected products written as constants.
        run_op(0, 1'b1, 32'h40, 32'h10, 32'h400);
        run_op(0, 1'b1, 32'd63, 32'd15, 32'h3B1);
        run_op(0, 1'b1, 32'h40, 32'd15, 32'hC40);
        run_op(0, 1'b1, 32'h7F, 32'h1F, 32'h001);
        run_op(0, 1'b0, 32'h7F, 32'h1F, 32'hF61);

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            run_op(0, rs, ra, rb, ref_prod(7, 5, rs, ra, rb));
        end

        // Hold start high with fresh operands every cycle. An operation is
        // queued only when the instance is ready.
        last_done = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (done0) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
                check_eq("stream_p", 32'(p0), e);
                $display("op stream cyc=%0d p=0x%0h exp=0x%0h", cyc, p0, e);
                if (last_done >= 0) check_eq("stream_period", 32'(cyc - last_done), 32'd7);
                last_done = cyc;
            end
            if (busy0 || done0) check_eq("stream_ready_low", 32'(rdy0), 32'd0);
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            if (rdy0) exp_q.push_back(ref_prod(7, 5, rs, ra, rb));
            drive(0, 1'b1, rs, ra, rb);
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            @(negedge clk);
            if (done0) begin
                e = exp_q.pop_front();
                check_eq("stream_drain_p", 32'(p0), e);
                $display("op stream-drain p=0x%0h exp=0x%0h", p0, e);
            end
        end
        check_eq("stream_queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);

        // Abort an operation with reset during its third RUN cycle.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h55, 32'h13);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_p", 32'(p0), 32'd0);
        check_eq("abort_busy", 32'(busy0), 32'd0);
        check_eq("abort_done", 32'(done0), 32'd0);
        check_eq("abort_ready", 32'(rdy0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done0) seen_done++;
        end
        check_eq("abort_no_done", 32'(seen_done), 32'd0);
        $display("op abort-recovery done_count=%0d", seen_done);
        run_op(0, 1'b1, 32'h55, 32'h13, ref_prod(7, 5, 1'b1, 32'h55, 32'h13));

        // Exhaustive sweeps on the 4x4 and 8x3 instances, both modes.
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    run_op(1, 1'(m), 32'(x), 32'(y), ref_prod(4, 4, 1'(m), 32'(x), 32'(y)));
        for (int m = 0; m < 2; m++)
            for (int x = 0; x < 256; x++)
                for (int y = 0; y < 8; y++)
                    run_op(2, 1'(m), 32'(x), 32'(y), ref_prod(8, 3, 1'(m), 32'(x), 32'(y)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
